// File: rtl/fd_handshake_fifo_if.sv
// Handshake bundle for fd_handshake_fifo: 4-phase left/right channels plus occupancy status.
// The slave modport is the FIFO's view; the master modport is the producer/consumer view.
interface fd_handshake_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             lreq;
  logic [WIDTH-1:0] ldata;
  logic             lack;
  logic             rreq;
  logic             rack;
  logic [WIDTH-1:0] rdata;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;

  modport slave (
    input  lreq, ldata, rack,
    output lack, rreq, rdata, count, full, empty
  );

  modport master (
    output lreq, ldata, rack,
    input  lack, rreq, rdata, count, full, empty
  );
endinterface

// File: rtl/fd_handshake_fifo.sv
// Clocked 4-phase handshake elastic buffer (DEPTH entries) between a PE and a NoC router port.
// Define FD_SYNC_EN to pass lreq/rack through SYNC_STAGES-flop synchronisers.
module fd_handshake_fifo #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  fd_handshake_fifo_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic [0:0] {IN_IDLE = 1'b0, IN_HOLD = 1'b1} in_state_t;
  typedef enum logic [1:0] {OUT_IDLE = 2'b00, OUT_REQ = 2'b01, OUT_REL = 2'b10} out_state_t;

  in_state_t        in_state_r, in_state_nxt_s;
  out_state_t       out_state_r, out_state_nxt_s;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [WIDTH-1:0] rdata_r;
  logic             lack_r, lack_nxt_s;
  logic             rreq_r, rreq_nxt_s;
  logic             wr_en_s, pop_s, load_s;
  logic             lreq_s, rack_s;
  logic             full_s, empty_s;

  if (DEPTH < 2 || SYNC_STAGES < 2) begin : g_param_check
    $error("fd_handshake_fifo: DEPTH and SYNC_STAGES must both be >= 2");
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_LAST) begin
      return {PTR_W{1'b0}};
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

`ifdef FD_SYNC_EN
  logic [SYNC_STAGES-1:0] lreq_sync_r, rack_sync_r;

  // Synchronisers for the handshake inputs from self-timed neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lreq_sync_r <= {SYNC_STAGES{1'b0}};
      rack_sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      lreq_sync_r <= {lreq_sync_r[SYNC_STAGES-2:0], bus.lreq};
      rack_sync_r <= {rack_sync_r[SYNC_STAGES-2:0], bus.rack};
    end
  end

  assign lreq_s = lreq_sync_r[SYNC_STAGES-1];
  assign rack_s = rack_sync_r[SYNC_STAGES-1];
`else
  assign lreq_s = bus.lreq;
  assign rack_s = bus.rack;
`endif

  assign full_s  = (count_r == CNT_FULL);
  assign empty_s = (count_r == {CNT_W{1'b0}});

  // Input FSM: accept one token per lreq phase, stall with lack low while full.
  always_comb begin
    in_state_nxt_s = in_state_r;
    lack_nxt_s     = lack_r;
    wr_en_s        = 1'b0;
    case (in_state_r)
      IN_IDLE: begin
        if (lreq_s && !full_s) begin
          wr_en_s        = 1'b1;
          lack_nxt_s     = 1'b1;
          in_state_nxt_s = IN_HOLD;
        end else begin
          lack_nxt_s = 1'b0;
        end
      end
      IN_HOLD: begin
        if (!lreq_s) begin
          lack_nxt_s     = 1'b0;
          in_state_nxt_s = IN_IDLE;
        end else begin
          lack_nxt_s = 1'b1;
        end
      end
      default: begin
        lack_nxt_s     = 1'b0;
        in_state_nxt_s = IN_IDLE;
      end
    endcase
  end

  // Output FSM: the head token stays counted until rack pops it.
  always_comb begin
    out_state_nxt_s = out_state_r;
    rreq_nxt_s      = rreq_r;
    load_s          = 1'b0;
    pop_s           = 1'b0;
    case (out_state_r)
      OUT_IDLE: begin
        if (!empty_s) begin
          load_s          = 1'b1;
          rreq_nxt_s      = 1'b1;
          out_state_nxt_s = OUT_REQ;
        end else begin
          rreq_nxt_s = 1'b0;
        end
      end
      OUT_REQ: begin
        if (rack_s) begin
          pop_s           = 1'b1;
          rreq_nxt_s      = 1'b0;
          out_state_nxt_s = OUT_REL;
        end else begin
          rreq_nxt_s = 1'b1;
        end
      end
      OUT_REL: begin
        rreq_nxt_s = 1'b0;
        if (!rack_s) begin
          out_state_nxt_s = OUT_IDLE;
        end else begin
          out_state_nxt_s = OUT_REL;
        end
      end
      default: begin
        rreq_nxt_s      = 1'b0;
        out_state_nxt_s = OUT_IDLE;
      end
    endcase
  end

  // State and handshake output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_state_r  <= IN_IDLE;
      out_state_r <= OUT_IDLE;
      lack_r      <= 1'b0;
      rreq_r      <= 1'b0;
    end else begin
      in_state_r  <= in_state_nxt_s;
      out_state_r <= out_state_nxt_s;
      lack_r      <= lack_nxt_s;
      rreq_r      <= rreq_nxt_s;
    end
  end

  // Pointers and occupancy; a simultaneous write and pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({wr_en_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Right data register, loaded only when a new output handshake starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= {WIDTH{1'b0}};
    end else if (load_s) begin
      rdata_r <= mem_r[rd_ptr_r];
    end
  end

  // Storage array; contents are invalidated by the pointer reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= bus.ldata;
    end
  end

  assign bus.lack  = lack_r;
  assign bus.rreq  = rreq_r;
  assign bus.rdata = rdata_r;
  assign bus.count = count_r;
  assign bus.full  = full_s;
  assign bus.empty = empty_s;
endmodule

// File: tb/tb_fd_handshake_fifo.sv
// Randomised self-checking bench for fd_handshake_fifo: a DEPTH=4 and a DEPTH=3 instance,
// each checked against a queue model; latencies follow FD_SYNC_EN.
module tb_fd_handshake_fifo;
  localparam int WIDTH = 8;
  localparam int SYNC_STAGES = 2;
  localparam int TMO = 100;
`ifdef FD_SYNC_EN
  localparam int LAT = SYNC_STAGES + 1;
`else
  localparam int LAT = 1;
`endif

  logic clk;
  logic rst_n;
  int   vec_cnt;
  int   err_cnt;

  logic             lreq_d  [2];
  logic [WIDTH-1:0] ldata_d [2];
  logic             rack_d  [2];
  logic             lack_o  [2];
  logic             rreq_o  [2];
  logic             full_o  [2];
  logic             empty_o [2];
  logic [WIDTH-1:0] rdata_o [2];
  logic [2:0]       cnt_o   [2];

  logic [WIDTH-1:0] mq0 [$];
  logic [WIDTH-1:0] mq1 [$];

  fd_handshake_fifo_if #(.WIDTH(WIDTH), .DEPTH(4)) b4 ();
  fd_handshake_fifo_if #(.WIDTH(WIDTH), .DEPTH(3)) b3 ();

  fd_handshake_fifo #(.WIDTH(WIDTH), .DEPTH(4), .SYNC_STAGES(SYNC_STAGES)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(b4.slave)
  );
  fd_handshake_fifo #(.WIDTH(WIDTH), .DEPTH(3), .SYNC_STAGES(SYNC_STAGES)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(b3.slave)
  );

  assign b4.lreq  = lreq_d[0];
  assign b4.ldata = ldata_d[0];
  assign b4.rack  = rack_d[0];
  assign b3.lreq  = lreq_d[1];
  assign b3.ldata = ldata_d[1];
  assign b3.rack  = rack_d[1];

  assign lack_o[0]  = b4.lack;
  assign rreq_o[0]  = b4.rreq;
  assign full_o[0]  = b4.full;
  assign empty_o[0] = b4.empty;
  assign rdata_o[0] = b4.rdata;
  assign cnt_o[0]   = b4.count;
  assign lack_o[1]  = b3.lack;
  assign rreq_o[1]  = b3.rreq;
  assign full_o[1]  = b3.full;
  assign empty_o[1] = b3.empty;
  assign rdata_o[1] = b3.rdata;
  assign cnt_o[1]   = {1'b0, b3.count};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void m_push(input int i, input logic [WIDTH-1:0] d);
    if (i == 0) mq0.push_back(d);
    else mq1.push_back(d);
  endfunction

  // Oldest token expected next; 32'hDEAD (unmatchable) when the model holds nothing.
  function automatic logic [31:0] m_pop(input int i);
    if (i == 0) begin
      if (mq0.size() > 0) return 32'(mq0.pop_front());
      else return 32'hDEAD;
    end else begin
      if (mq1.size() > 0) return 32'(mq1.pop_front());
      else return 32'hDEAD;
    end
  endfunction

  function automatic int m_size(input int i);
    return (i == 0) ? mq0.size() : mq1.size();
  endfunction

  task automatic push(input int i, input logic [WIDTH-1:0] d);
    int n;
    @(negedge clk);
    lreq_d[i]  = 1'b1;
    ldata_d[i] = d;
    n = 0;
    while (!lack_o[i] && n < TMO) begin
      @(negedge clk);
      n++;
    end
    check_eq("push_ack", 32'(lack_o[i]), 32'd1);
    if (lack_o[i]) m_push(i, d);
    lreq_d[i] = 1'b0;
    n = 0;
    while (lack_o[i] && n < TMO) begin
      @(negedge clk);
      n++;
    end
    check_eq("push_release", 32'(lack_o[i]), 32'd0);
  endtask

  task automatic pull(input int i);
    int n;
    logic [31:0] exp;
    @(negedge clk);
    n = 0;
    while (!rreq_o[i] && n < TMO) begin
      @(negedge clk);
      n++;
    end
    check_eq("pull_req", 32'(rreq_o[i]), 32'd1);
    exp = m_pop(i);
    check_eq("pull_data", 32'(rdata_o[i]), exp);
    rack_d[i] = 1'b1;
    n = 0;
    while (rreq_o[i] && n < TMO) begin
      @(negedge clk);
      n++;
    end
    check_eq("pull_rreq_drop", 32'(rreq_o[i]), 32'd0);
    check_eq("pull_data_hold", 32'(rdata_o[i]), exp);
    rack_d[i] = 1'b0;
  endtask

  task automatic stream(input int i, input int num, input bit rnd);
    fork
      for (int k = 0; k < num; k++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        push(i, rnd ? WIDTH'($urandom) : WIDTH'(k));
      end
      for (int k = 0; k < num; k++) begin
        repeat ($urandom_range(0, 4)) @(negedge clk);
        pull(i);
      end
    join
    repeat (2 * LAT + 4) @(negedge clk);
    check_eq("drain_count", 32'(cnt_o[i]), 32'd0);
    check_eq("drain_empty", 32'(empty_o[i]), 32'd1);
    check_eq("drain_model", 32'(m_size(i)), 32'd0);
  endtask

  task automatic wait_rreq(input int i);
    int n;
    n = 0;
    while (!rreq_o[i] && n < TMO) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int first;
    vec_cnt = 0;
    err_cnt = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      lreq_d[i]  = 1'b0;
      ldata_d[i] = '0;
      rack_d[i]  = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 2; i++) begin
      check_eq("rst_lack",  32'(lack_o[i]),  32'd0);
      check_eq("rst_rreq",  32'(rreq_o[i]),  32'd0);
      check_eq("rst_rdata", 32'(rdata_o[i]), 32'd0);
      check_eq("rst_count", 32'(cnt_o[i]),   32'd0);
      check_eq("rst_full",  32'(full_o[i]),  32'd0);
      check_eq("rst_empty", 32'(empty_o[i]), 32'd1);
    end

    // Single token with latency measurement.
    @(negedge clk);
    lreq_d[0]  = 1'b1;
    ldata_d[0] = 8'hAA;
    first = 0;
    for (int k = 1; k <= LAT + 4 && first == 0; k++) begin
      @(posedge clk);
      #1;
      if (lack_o[0]) first = k;
    end
    check_eq("t1_lack_latency", 32'(first), 32'(LAT));
    m_push(0, 8'hAA);
    @(posedge clk);
    #1;
    check_eq("t1_rreq", 32'(rreq_o[0]), 32'd1);
    check_eq("t1_rdata", 32'(rdata_o[0]), m_pop(0));
    @(negedge clk);
    rack_d[0] = 1'b1;
    first = 0;
    for (int k = 1; k <= LAT + 4 && first == 0; k++) begin
      @(posedge clk);
      #1;
      if (!rreq_o[0]) first = k;
    end
    check_eq("t1_rack_latency", 32'(first), 32'(LAT));
    @(negedge clk);
    lreq_d[0] = 1'b0;
    rack_d[0] = 1'b0;
    repeat (2 * LAT + 2) @(negedge clk);
    check_eq("t1_lack_low", 32'(lack_o[0]),  32'd0);
    check_eq("t1_rreq_low", 32'(rreq_o[0]),  32'd0);
    check_eq("t1_count",    32'(cnt_o[0]),   32'd0);
    check_eq("t1_empty",    32'(empty_o[0]), 32'd1);

    // Full and backpressure.
    for (int k = 0; k < 4; k++) push(0, WIDTH'(8'h11 * (k + 1)));
    repeat (LAT + 2) @(negedge clk);
    check_eq("t2_count", 32'(cnt_o[0]),  32'd4);
    check_eq("t2_full",  32'(full_o[0]), 32'd1);
    fork
      push(0, 8'h55);
      begin
        repeat (8) @(negedge clk);
        check_eq("t2_blocked", 32'(lack_o[0]), 32'd0);
        check_eq("t2_count_held", 32'(cnt_o[0]), 32'd4);
        pull(0);
      end
    join
    for (int k = 0; k < 4; k++) pull(0);
    repeat (2 * LAT + 2) @(negedge clk);
    check_eq("t2_empty", 32'(empty_o[0]), 32'd1);

    // Pointer wrap at DEPTH=4 and DEPTH=3.
    stream(0, 10, 1'b0);
    stream(1, 10, 1'b0);

    // Simultaneous write and pop with two tokens held.
    push(0, 8'hA1);
    push(0, 8'hB2);
    wait_rreq(0);
    check_eq("t4_rreq",  32'(rreq_o[0]),  32'd1);
    check_eq("t4_count", 32'(cnt_o[0]),   32'd2);
    check_eq("t4_head",  32'(rdata_o[0]), m_pop(0));
    @(negedge clk);
    lreq_d[0]  = 1'b1;
    ldata_d[0] = 8'hC3;
    rack_d[0]  = 1'b1;
    repeat (LAT) @(posedge clk);
    #1;
    check_eq("t4_count_same", 32'(cnt_o[0]),  32'd2);
    check_eq("t4_lack",       32'(lack_o[0]), 32'd1);
    check_eq("t4_rreq_drop",  32'(rreq_o[0]), 32'd0);
    m_push(0, 8'hC3);
    @(negedge clk);
    lreq_d[0] = 1'b0;
    rack_d[0] = 1'b0;
    pull(0);
    pull(0);

    // Randomised concurrent traffic on both instances.
    fork
      stream(0, 40, 1'b1);
      stream(1, 40, 1'b1);
    join

    // Asynchronous reset in the middle of operation.
    push(0, 8'h61);
    push(0, 8'h62);
    push(0, 8'h63);
    wait_rreq(0);
    check_eq("t5_count", 32'(cnt_o[0]),  32'd3);
    check_eq("t5_rreq",  32'(rreq_o[0]), 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t5_rreq_rst",  32'(rreq_o[0]),  32'd0);
    check_eq("t5_lack_rst",  32'(lack_o[0]),  32'd0);
    check_eq("t5_rdata_rst", 32'(rdata_o[0]), 32'd0);
    check_eq("t5_empty_rst", 32'(empty_o[0]), 32'd1);
    check_eq("t5_count_rst", 32'(cnt_o[0]),   32'd0);
    mq0.delete();
    mq1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_eq("t5_no_rreq", 32'(rreq_o[0]), 32'd0);
    end
    push(0, 8'h77);
    pull(0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
